// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode-side signals of the fetch stage
interface fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        input  imem_ready, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode,
        output imem_ready, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding imem request, output register with one-entry skid buffer
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master fu
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;

    logic            consume;
    logic [XLEN-1:0] target;

    assign consume = instr_valid_q && !fu.stall;
    assign target  = fu.redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_addr_q  <= RESET_PC;
            pending_pc_q  <= '0;
            instr_q       <= NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pending_pc_q  <= pending_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        pending_pc_d  = pending_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;

        // A consumed instruction leaves the output empty unless refilled below.
        if (consume) begin
            instr_valid_d = 1'b0;
        end

        if (fu.redirect) begin
            instr_valid_d = 1'b0;
            buf_instr_d   = '0;
            buf_pc_d      = '0;
            if ((state_q == FETCH || state_q == DISCARD) && !fu.imem_ready) begin
                // Keep the open request stable; retarget once it completes.
                pending_pc_d = target;
                state_d      = DISCARD;
            end else begin
                fetch_addr_d = target;
                state_d      = FETCH;
            end
        end else begin
            unique case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (fu.imem_ready) begin
                        fetch_addr_d = fetch_addr_q + XLEN'(4);
                        if (!instr_valid_q || consume) begin
                            instr_d       = fu.imem_rdata;
                            instr_pc_d    = fetch_addr_q;
                            instr_valid_d = 1'b1;
                        end else begin
                            buf_instr_d = fu.imem_rdata;
                            buf_pc_d    = fetch_addr_q;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        instr_d       = buf_instr_q;
                        instr_pc_d    = buf_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = FETCH;
                    end
                end
                DISCARD: begin
                    if (fu.imem_ready) begin
                        fetch_addr_d = pending_pc_q;
                        state_d      = FETCH;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign fu.imem_req    = (state_q == FETCH) || (state_q == DISCARD);
    assign fu.imem_addr   = fetch_addr_q;
    assign fu.instr_valid = instr_valid_q;
    assign fu.instr       = instr_q;
    assign fu.instr_pc    = instr_pc_q;
    assign fu.opcode      = instr_q[6:0];
endmodule
